// File: rtl/vector_mem_sequencer.sv
// Memory-stage sequencer: drains one LANES*LANE_W vector load/store as LANES byte accesses on a byte RAM.
// Optional misaligned-base rejection is enabled by defining VMEM_ALIGN_CHECK_EN.
module vector_mem_sequencer #(
    parameter int ADDR_W = 12,
    parameter int LANES  = 16,
    parameter int LANE_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [LANES*LANE_W-1:0]   req_wdata,
    output logic                      stall,
    output logic                      done,
    output logic [LANES*LANE_W-1:0]   rdata_vec,
    output logic                      rdata_valid,
    output logic                      align_err,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LANE_W-1:0]         mem_wdata,
    output logic                      mem_we,
    input  logic [LANE_W-1:0]         mem_rdata
);

    localparam int VEC_W = LANES * LANE_W;
    localparam int LW    = $clog2(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ      = 3'd2,
        ST_READ_LAST = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t                   state_r;
    logic [LW-1:0]            lane_r;
    logic [ADDR_W-1:0]        base_r;
    // Lane 0 goes straight to mem_wdata at accept; only lanes 1..LANES-1 are held.
    logic [VEC_W-LANE_W-1:0]  store_r;
    // Lanes 0..LANES-2 of a load; the last lane is taken directly from mem_rdata.
    logic [VEC_W-LANE_W-1:0]  load_r;
    logic [LW-1:0]            next_lane_s;
    logic [LW-1:0]            prev_lane_s;
    logic                     misaligned_s;

    function automatic logic [LANE_W-1:0] lane_of(input logic [VEC_W-LANE_W-1:0] vec,
                                                  input logic [LW-1:0] idx);
        return vec[idx*LANE_W +: LANE_W];
    endfunction

    // Lane neighbours and alignment decode of the presented request
    always_comb begin
        next_lane_s = lane_r + LW'(1);
        prev_lane_s = lane_r - LW'(1);
`ifdef VMEM_ALIGN_CHECK_EN
        misaligned_s = |req_addr[LW-1:0];
`else
        misaligned_s = 1'b0;
`endif
    end

    assign stall = ((state_r != ST_IDLE) && (state_r != ST_DONE)) ||
                   ((state_r == ST_IDLE) && req_valid);

    // Sequencer FSM with registered memory and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            lane_r      <= {LW{1'b0}};
            base_r      <= {ADDR_W{1'b0}};
            store_r     <= {(VEC_W-LANE_W){1'b0}};
            load_r      <= {(VEC_W-LANE_W){1'b0}};
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            align_err   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_wdata   <= {LANE_W{1'b0}};
            rdata_vec   <= {VEC_W{1'b0}};
        end else begin
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            align_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        base_r  <= req_addr;
                        store_r <= req_wdata[VEC_W-1:LANE_W];
                        lane_r  <= {LW{1'b0}};
                        if (misaligned_s) begin
                            state_r   <= ST_DONE;
                            mem_we    <= 1'b0;
                            done      <= 1'b1;
                            align_err <= 1'b1;
                        end else if (req_write) begin
                            state_r   <= ST_WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata[LANE_W-1:0];
                        end else begin
                            state_r   <= ST_READ;
                            mem_we    <= 1'b0;
                            mem_addr  <= req_addr;
                        end
                    end else begin
                        mem_we <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (lane_r == LAST_LANE) begin
                        state_r <= ST_DONE;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        lane_r    <= next_lane_s;
                        mem_we    <= 1'b1;
                        mem_addr  <= base_r + ADDR_W'(next_lane_s);
                        mem_wdata <= lane_of(store_r, lane_r);
                    end
                end
                ST_READ: begin
                    mem_we <= 1'b0;
                    // RAM data lags the address by one cycle, so lane i-1 arrives while lane i is addressed.
                    if (lane_r != {LW{1'b0}}) begin
                        load_r[prev_lane_s*LANE_W +: LANE_W] <= mem_rdata;
                    end
                    if (lane_r == LAST_LANE) begin
                        state_r <= ST_READ_LAST;
                    end else begin
                        lane_r   <= next_lane_s;
                        mem_addr <= base_r + ADDR_W'(next_lane_s);
                    end
                end
                ST_READ_LAST: begin
                    mem_we      <= 1'b0;
                    rdata_vec   <= {mem_rdata, load_r};
                    rdata_valid <= 1'b1;
                    done        <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    mem_we  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_we  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer: directed vector accesses against a byte RAM model.
// Exercises the misaligned-reject path when VMEM_ALIGN_CHECK_EN is defined.
module tb_vector_mem_sequencer;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_write;
    logic [11:0]  req_addr;
    logic [127:0] req_wdata;
    logic         stall;
    logic         done;
    logic [127:0] rdata_vec;
    logic         rdata_valid;
    logic         align_err;
    logic [11:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic         mem_we;
    logic [7:0]   mem_rdata;

    vector_mem_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .done        (done),
        .rdata_vec   (rdata_vec),
        .rdata_valid (rdata_valid),
        .align_err   (align_err),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    typedef struct {
        logic         is_load;
        logic         align;
        logic [127:0] data;
        int           done_cyc;
    } exp_t;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wlog[$];
    exp_t e;
    logic [7:0] ram [0:4095];
    int   cyc;
    int   total;
    int   bad;
    logic prev_stall;

    localparam logic [127:0] D1 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] D2 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    localparam logic [127:0] D3 = 128'h123456789ABCDEF00FEDCBA987654321;
    localparam logic [127:0] D_ALL_FF = {16{8'hFF}};
    // Load of 0x100 after a store of all-FF aborted after six bytes.
    localparam logic [127:0] D_ABORT = 128'h5554575651505352_5D5CFFFFFFFFFFFF;

    function automatic logic [7:0] init_byte(input int a);
        logic [11:0] aa;
        aa = 12'(a);
        return aa[7:0] ^ 8'h5A;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = init_byte(i);
    end

    // Byte RAM with one-cycle synchronous read
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: logs RAM writes and scores every done pulse against the queue
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wlog.push_back('{mem_addr, mem_wdata});
            chk("we_implies_stall", stall, 1'b1);
        end
        if (rdata_valid === 1'b1) chk("rvalid_implies_done", done, 1'b1);
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("align_err", align_err, e.align);
                chk("rdata_valid", rdata_valid, e.is_load);
                chk("stall_in_done", stall, 1'b0);
                chk("stall_before_done", prev_stall, 1'b1);
                if (e.is_load) chk("rdata_vec", rdata_vec, e.data);
            end
        end
        prev_stall = stall;
    end

    task automatic issue(input logic wr, input logic [11:0] addr, input logic [127:0] wdata,
                         input logic [127:0] exp_data, input logic exp_align,
                         input logic hold, input logic push, output int t);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        t = cyc;
        if (push) exp_q.push_back('{!wr, exp_align, exp_data,
                                    exp_align ? t + 1 : (wr ? t + 17 : t + 18)});
        @(negedge clk);
        chk("stall_at_accept", stall, 1'b1);
        @(posedge clk); #1;
        if (!hold) begin
            req_valid = 1'b0;
            req_wdata = ~wdata;
            req_addr  = addr + 12'h123;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 60);
        chk("done_seen", done, 1'b1);
    endtask

    task automatic check_wlog(input string name, input logic [11:0] base, input logic [127:0] data);
        logic [11:0] a;
        chk({name, "_write_count"}, wlog.size(), 16);
        for (int i = 0; i < 16 && i < wlog.size(); i++) begin
            a = base + 12'(i);
            chk({name, "_addr"}, wlog[i].addr, a);
            chk({name, "_wdata"}, wlog[i].data, data[i*8 +: 8]);
        end
    endtask

    initial begin
        int t;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 12'h000;
        req_wdata = 128'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_rdata_valid", rdata_valid, 1'b0);
        chk("rst_align_err", align_err, 1'b0);
        chk("rst_rdata_vec", rdata_vec, 128'h0);
        chk("rst_mem_addr", mem_addr, 12'h000);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic store then load at 0x040
        wlog.delete();
        issue(1'b1, 12'h040, D1, 128'h0, 1'b0, 1'b0, 1'b1, t);
        wait_done();
        check_wlog("store040", 12'h040, D1);
        wlog.delete();
        issue(1'b0, 12'h040, 128'h0, D1, 1'b0, 1'b0, 1'b1, t);
        wait_done();
        chk("load040_no_writes", wlog.size(), 0);

`ifdef VMEM_ALIGN_CHECK_EN
        // Misaligned store rejected, then aligned access completes
        wlog.delete();
        issue(1'b1, 12'h043, D2, 128'h0, 1'b1, 1'b0, 1'b1, t);
        wait_done();
        repeat (2) @(negedge clk);
        chk("misaligned_no_writes", wlog.size(), 0);
        wlog.delete();
        issue(1'b1, 12'h050, D2, 128'h0, 1'b0, 1'b0, 1'b1, t);
        wait_done();
        check_wlog("store050", 12'h050, D2);
        issue(1'b0, 12'h050, 128'h0, D2, 1'b0, 1'b0, 1'b1, t);
        wait_done();
`else
        // Store/load wrapping across the top of the address space
        wlog.delete();
        issue(1'b1, 12'hFF8, D2, 128'h0, 1'b0, 1'b0, 1'b1, t);
        wait_done();
        check_wlog("storeFF8", 12'hFF8, D2);
        if (wlog.size() > 8) chk("wrap_addr8", wlog[8].addr, 12'h000);
        issue(1'b0, 12'hFF8, 128'h0, D2, 1'b0, 1'b0, 1'b1, t);
        wait_done();
`endif

        // req_valid held through DONE: one store only, then a load accepted at DONE+1
        wlog.delete();
        issue(1'b1, 12'h200, D3, 128'h0, 1'b0, 1'b1, 1'b1, t);
        wait_done();
        @(posedge clk); #1;
        req_write = 1'b0;
        t = cyc;
        exp_q.push_back('{1'b1, 1'b0, D3, t + 18});
        @(negedge clk);
        chk("hold_accept_stall", stall, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done();
        check_wlog("hold_store", 12'h200, D3);

        // Reset in cycle T+6 of a store aborts it
        wlog.delete();
        issue(1'b1, 12'h100, D_ALL_FF, 128'h0, 1'b0, 1'b0, 1'b0, t);
        while (cyc < t + 6) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_mem_we", mem_we, 1'b0);
        chk("abort_stall", stall, 1'b0);
        chk("abort_rdata_vec", rdata_vec, 128'h0);
        repeat (4) @(negedge clk);
        chk("abort_write_count", wlog.size(), 6);
        for (int k = 0; k < 16; k++) begin
            chk("abort_ram_byte", ram[12'h100 + 12'(k)],
                (k < 6) ? 8'hFF : init_byte(12'h100 + k));
        end
        issue(1'b0, 12'h100, 128'h0, D_ABORT, 1'b0, 1'b0, 1'b1, t);
        wait_done();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
